// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fq_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Memory-read, redirect and decode handshake bundle of the fetch unit.
interface instr_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int MEM_ADDR_W = 10
);

  logic                  Mem_Rd;
  logic [MEM_ADDR_W-1:0] Mem_Addr;
  logic [INSTR_W-1:0]    Mem_Data;
  logic                  Redirect;
  logic [31:0]           Redirect_PC;
  logic [INSTR_W-1:0]    Instr;
  logic [31:0]           Instr_PC;
  logic                  Instr_Valid;
  logic                  Instr_Ready;

  modport master (
    output Mem_Rd, Mem_Addr, Instr, Instr_PC, Instr_Valid,
    input  Mem_Data, Redirect, Redirect_PC, Instr_Ready
  );

  modport slave (
    input  Mem_Rd, Mem_Addr, Instr, Instr_PC, Instr_Valid,
    output Mem_Data, Redirect, Redirect_PC, Instr_Ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-register FIFO of {instr, pc}; entry 0 is the head register seen by decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fq_entry_t        push_data,
  output fq_entry_t        head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  fq_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  do_pop_s, do_push_s;
  logic [CNT_W-1:0]      wr_idx_s;

  // Next-state: flush wins; otherwise shift on pop and write behind the last live entry.
  always_comb begin
    ent_d     = ent_q;
    count_d   = count_q;
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    wr_idx_s  = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      do_pop_s  = pop && (count_q != '0);
      wr_idx_s  = count_q - CNT_W'(do_pop_s);
      do_push_s = push && (wr_idx_s < CNT_W'(DEPTH));
      if (do_pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          ent_d[i] = ent_q[i+1];
        end
      end else begin
        ent_d = ent_d;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push_s && (wr_idx_s == CNT_W'(i))) begin
          ent_d[i] = push_data;
        end else begin
          ent_d[i] = ent_d[i];
        end
      end
      count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
    valid_d = (count_d != '0);
  end

  // Queue storage, occupancy and registered head-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{instr: NOP, pc: 32'h0000_0000};
      end
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head       = ent_q[0];
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: PC, single outstanding ROM read, redirect handling and the
// instruction queue that feeds decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter int          MEM_ADDR_W = 10,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input logic                Clk,
  input logic                Reset_n,
  instr_fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]           pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [31:0]           inflight_pc_q, inflight_pc_d;

  logic [31:0]           target_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic                  mem_rd_s;
  logic [MEM_ADDR_W-1:0] mem_addr_s;
  logic [OCC_W-1:0]      occ_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic                  fifo_valid_s;
  fq_entry_t             fifo_head_s;
  fq_entry_t             push_entry_s;

  // Issue/redirect decision. Occupancy counts the read already in flight so the
  // queue can never be overrun; a redirect overrides everything else.
  always_comb begin
    target_s      = align_pc(bus.Redirect_PC);
    pop_s         = fifo_valid_s && bus.Instr_Ready && !bus.Redirect;
    push_s        = inflight_q && !bus.Redirect;
    occ_s         = {1'b0, fifo_count_s} + OCC_W'(inflight_q) - OCC_W'(pop_s);
    issue_s       = (occ_s < OCC_W'(DEPTH));
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    mem_rd_s      = 1'b0;
    mem_addr_s    = pc_q[MEM_ADDR_W+1:2];
    if (bus.Redirect) begin
      mem_rd_s      = 1'b1;
      mem_addr_s    = target_s[MEM_ADDR_W+1:2];
      pc_d          = target_s + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = target_s;
    end else if (issue_s) begin
      mem_rd_s      = 1'b1;
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else begin
      inflight_d    = 1'b0;
    end
  end

  // PC and outstanding-read tracking.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry_s = '{instr: bus.Mem_Data, pc: inflight_pc_q};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (bus.Redirect),
    .push_data  (push_entry_s),
    .head       (fifo_head_s),
    .head_valid (fifo_valid_s),
    .count      (fifo_count_s)
  );

  // Read strobe drops the moment reset asserts, not at the next edge.
  assign bus.Mem_Rd      = mem_rd_s & Reset_n;
  assign bus.Mem_Addr    = mem_addr_s;
  assign bus.Instr       = fifo_head_s.instr;
  assign bus.Instr_PC    = fifo_head_s.pc;
  assign bus.Instr_Valid = fifo_valid_s;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue against a ROM holding word k = k + 100.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int MEM_ADDR_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks   = 0;
  int   n_failures = 0;

  instr_fetch_queue_if #(.MEM_ADDR_W(MEM_ADDR_W)) bus_if ();

  instr_fetch_queue #(
    .DEPTH      (4),
    .MEM_ADDR_W (MEM_ADDR_W),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus_if.master)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model
  always @(posedge clk) begin
    if (bus_if.Mem_Rd) bus_if.Mem_Data <= 32'(bus_if.Mem_Addr) + 32'd100;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return {22'd0, pc[11:2]} + 32'd100;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 64'(bus_if.Instr_Valid), 64'd1);
    check_eq({tag, "_pc"}, 64'(bus_if.Instr_PC), 64'(pc));
    check_eq({tag, "_instr"}, 64'(bus_if.Instr), 64'(rom_word(pc)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.Redirect    = 1'b0;
    bus_if.Redirect_PC = 32'h0;
    bus_if.Instr_Ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(bus_if.Instr_Valid), 64'd0);
    check_eq("rst_rd", 64'(bus_if.Mem_Rd), 64'd0);
    check_eq("rst_instr", 64'(bus_if.Instr), 64'd0);
    check_eq("rst_pc", 64'(bus_if.Instr_PC), 64'd0);

    // Release: cycle 0 issues at RESET_PC
    #1 rst_n = 1'b1;
    #1;
    check_eq("c0_rd", 64'(bus_if.Mem_Rd), 64'd1);
    check_eq("c0_addr", 64'(bus_if.Mem_Addr), 64'd0);
    check_eq("c0_valid", 64'(bus_if.Instr_Valid), 64'd0);
    tick();
    check_eq("c1_valid", 64'(bus_if.Instr_Valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_head("stream", 32'(4 * i));
    end

    // Stall decode for 10 cycles: queue fills and issue stops
    tick();
    bus_if.Instr_Ready = 1'b0;
    #1;
    expect_head("stall_first", 32'd24);
    for (int k = 1; k < 10; k++) tick();
    check_eq("stall_rd", 64'(bus_if.Mem_Rd), 64'd0);
    expect_head("stall_last", 32'd24);
    for (int j = 0; j < 8; j++) begin
      tick();
      bus_if.Instr_Ready = 1'b1;
      #1;
      expect_head("resume", 32'(24 + 4 * j));
    end

    // Redirect with 3 queued entries and one read in flight
    tick();
    bus_if.Redirect    = 1'b1;
    bus_if.Redirect_PC = 32'h40;
    #1;
    check_eq("redir_head_pc", 64'(bus_if.Instr_PC), 64'd56);
    check_eq("redir_rd", 64'(bus_if.Mem_Rd), 64'd1);
    check_eq("redir_addr", 64'(bus_if.Mem_Addr), 64'h10);
    tick();
    bus_if.Redirect = 1'b0;
    #1;
    check_eq("redir_flush", 64'(bus_if.Instr_Valid), 64'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      expect_head("redir", 32'(32'h40 + 4 * j));
    end

    // Misaligned target issued alone
    tick();
    bus_if.Redirect    = 1'b1;
    bus_if.Redirect_PC = 32'h43;
    #1;
    check_eq("mis_addr", 64'(bus_if.Mem_Addr), 64'h10);
    tick();
    bus_if.Redirect = 1'b0;
    #1;
    check_eq("mis_flush", 64'(bus_if.Instr_Valid), 64'd0);
    tick();
    expect_head("mis", 32'h40);
    tick();
    expect_head("mis", 32'h44);

    // Back-to-back redirects: only the second target survives
    tick();
    bus_if.Redirect    = 1'b1;
    bus_if.Redirect_PC = 32'h80;
    #1;
    check_eq("b2b_addr0", 64'(bus_if.Mem_Addr), 64'h20);
    tick();
    bus_if.Redirect_PC = 32'hC0;
    #1;
    check_eq("b2b_addr1", 64'(bus_if.Mem_Addr), 64'h30);
    check_eq("b2b_flush0", 64'(bus_if.Instr_Valid), 64'd0);
    tick();
    bus_if.Redirect = 1'b0;
    #1;
    check_eq("b2b_flush1", 64'(bus_if.Instr_Valid), 64'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      expect_head("b2b", 32'(32'hC0 + 4 * j));
    end

    // PC wrap at the top of the address space
    tick();
    bus_if.Redirect    = 1'b1;
    bus_if.Redirect_PC = 32'hFFFF_FFFC;
    #1;
    check_eq("wrap_addr_top", 64'(bus_if.Mem_Addr), 64'h3FF);
    tick();
    bus_if.Redirect = 1'b0;
    #1;
    check_eq("wrap_rd", 64'(bus_if.Mem_Rd), 64'd1);
    check_eq("wrap_addr_zero", 64'(bus_if.Mem_Addr), 64'd0);
    check_eq("wrap_flush", 64'(bus_if.Instr_Valid), 64'd0);
    tick();
    expect_head("wrap", 32'hFFFF_FFFC);
    check_eq("wrap_addr_one", 64'(bus_if.Mem_Addr), 64'd1);
    tick();
    expect_head("wrap", 32'h0);

    // Asynchronous reset pulse between edges
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(bus_if.Instr_Valid), 64'd0);
    check_eq("arst_rd", 64'(bus_if.Mem_Rd), 64'd0);
    check_eq("arst_pc", 64'(bus_if.Instr_PC), 64'd0);
    tick();
    #1 rst_n = 1'b1;
    #1;
    check_eq("rerun_c0_rd", 64'(bus_if.Mem_Rd), 64'd1);
    check_eq("rerun_c0_addr", 64'(bus_if.Mem_Addr), 64'd0);
    check_eq("rerun_c0_valid", 64'(bus_if.Instr_Valid), 64'd0);
    tick();
    check_eq("rerun_c1_valid", 64'(bus_if.Instr_Valid), 64'd0);
    tick();
    expect_head("rerun", 32'h0);
    tick();
    expect_head("rerun", 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction-fetch front end feeding the processor's decode/execute datapath. Holds the program counter and issues word reads to the synchronous instruction memory. Buffers returned instructions with their PCs in a small FIFO, presenting them to decode over a valid/ready handshake. On a taken branch or jump, decode drives a redirect, which flushes all buffered and in-flight instructions.

## Interface
- DEPTH, 4, instruction queue entries (≥2).
- MEM_ADDR_W, 10, instruction-memory word-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset; one clock domain only.
- Mem_Rd  out  1  instruction-memory read strobe.
- Mem_Addr  out  MEM_ADDR_W  word address, equal to PC[MEM_ADDR_W+1:2].
- Mem_Data  in  32  read data, valid the cycle after a Mem_Rd cycle (synchronous ROM).
- Redirect  in  1  taken branch/jump from decode.
- Redirect_PC  in  32  target byte address; bits [1:0] are forced to 0.
- Instr  out  32  instruction at queue head.
- Instr_PC  out  32  byte address of Instr.
- Instr_Valid  out  1  queue head valid.
- Instr_Ready  in  1  decode accepts the head this cycle.

## Operation
- State:
  - PC register.
  - Queue of {instr, pc}, DEPTH entries, with a count.
  - inflight flag plus inflight_pc for the single outstanding memory read.
- Pop: Instr_Valid && Instr_Ready && !Redirect.
- Issue condition (normal cycle): count + inflight − pop < DEPTH.
  - Mem_Rd=1 and Mem_Addr from PC.
  - PC ← PC+4, wrapping mod 2^32.
  - inflight ← 1; inflight_pc ← PC.
- Return: when inflight is set, push {Mem_Data, inflight_pc} into the queue at the clock edge, unless flushed.
- Push and pop in the same cycle keep count unchanged; a full queue never receives a push, because the issue condition guarantees it.
- Redirect cycle:
  - Queue flushed: count ← 0, pointers reset.
  - Any return arriving this cycle is discarded.
  - Mem_Rd=1, with Mem_Addr taken combinationally from Redirect_PC.
  - PC ← {Redirect_PC[31:2],2'b00}+4.
  - inflight ← 1; inflight_pc ← aligned target.
  - Pop is suppressed.
- Redirect takes priority over every other event. Back-to-back redirects: each one cancels the previous fetch.
- Outputs Instr, Instr_PC and Instr_Valid come from queue-head registers. When Instr_Valid=0, Instr and Instr_PC hold their last value (don't-care).
- Mem_Addr wraps naturally when the PC exceeds the memory size; no error is flagged.

## Timing
- Reset (async assert, synchronous release):
  - PC=RESET_PC, count=0, inflight=0.
  - Instr_Valid=0, Mem_Rd=0, Instr=0, Instr_PC=0.
- Cycle 0 is the first cycle with Reset_n high. It issues at RESET_PC.
- Fetch latency: an issue in cycle N gives Instr_Valid=1 in cycle N+2. Redirect-to-target-visible is also 2 cycles.
- Throughput: 1 instruction/cycle sustained while Instr_Ready=1 (DEPTH≥2).
- Instr_Ready low for k cycles: the queue fills to DEPTH and issue stops with no overrun. After Ready returns, the stream resumes with no gap.
- Reset asserted mid-operation: all state clears immediately and in-flight data is dropped. Mem_Rd deasserts asynchronously.

## Structure
- Package fetch_pkg holds:
  - INSTR_W=32.
  - RESET_PC default.
  - NOP encoding 32'h0000_0000.
  - Queue-entry struct {instr, pc}.
- Sub-module fetch_fifo: synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count and head data.
  - Parameterised by DEPTH; flush has priority over push/pop.
- The top level holds the PC, inflight tracking, the issue condition and the redirect muxing; estimated at ~200 lines of RTL total.

## Test plan
- Reset release with Instr_Ready=1 and ROM word k=k+100:
  - Instr_Valid rises in cycle 2 with Instr=100, Instr_PC=0.
  - Then Instr=101,102,… with Instr_PC=4,8,… every cycle.
- Instr_Ready=0 for 10 cycles, DEPTH=4:
  - Count saturates at 4 and Mem_Rd drops.
  - On Ready, PCs 0,4,8,12,16… are delivered in order with no duplicates or skips.
- Redirect to 0x40 while the queue holds 3 entries and one read is in flight:
  - Next-cycle Instr_Valid=0.
  - Two cycles later, Instr_PC=0x40, followed by 0x44.
  - No pre-redirect PC appears afterwards.
- Redirect_PC=0x43 and back-to-back redirects to 0x80 then 0xC0:
  - Only 0xC0, 0xC4… are delivered.
  - The misaligned target is delivered as 0x40 when issued alone.
- Reset_n pulsed low mid-stream between edges:
  - Instr_Valid and Mem_Rd go to 0 immediately.
  - After release, fetch restarts at RESET_PC with latency 2.
- PC=0xFFFF_FFFC via redirect:
  - Delivers 0xFFFF_FFFC, then 0x0000_0000.
  - Mem_Addr wraps to all-ones, then 0.
